// File: rtl/dll_rx_ack_nak_if.sv
// Receive-side TLP sequence checker bundle: TLP status in, accept/drop pulses and ACK/NAK DLLP request out.
// The request half is valid/ready; the TLP half has no backpressure.
interface dll_rx_ack_nak_if;
  logic        rx_tlp_vld_i;
  logic [11:0] rx_seq_num_i;
  logic        rx_lcrc_ok_i;
  logic        tlp_accept_o;
  logic        tlp_drop_o;
  logic        ack_nack_o;
  logic [11:0] ack_seq_num_o;
  logic        ack_nack_vld_o;
  logic        ack_nack_rdy_i;
  logic [11:0] next_rcv_seq_o;

  modport master (
    input  rx_tlp_vld_i, rx_seq_num_i, rx_lcrc_ok_i, ack_nack_rdy_i,
    output tlp_accept_o, tlp_drop_o, ack_nack_o, ack_seq_num_o, ack_nack_vld_o, next_rcv_seq_o
  );
  modport slave (
    output rx_tlp_vld_i, rx_seq_num_i, rx_lcrc_ok_i, ack_nack_rdy_i,
    input  tlp_accept_o, tlp_drop_o, ack_nack_o, ack_seq_num_o, ack_nack_vld_o, next_rcv_seq_o
  );
endinterface

// File: rtl/dll_rx_ack_nak.sv
// PCIe DLL receive sequence checker: accept/drop 1 cycle after the TLP, NAK request 2 cycles after an error.
// ACK/NAK requests hold stable under ack_nack_rdy_i backpressure; TLP input is never stalled.
module dll_rx_ack_nak #(
  parameter int ACK_LATENCY  = 160,
  parameter int ACK_COALESCE = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              link_up_i,
  dll_rx_ack_nak_if.master bus
);
  localparam int TW = $clog2(ACK_LATENCY + 1);
  localparam logic [TW-1:0] LAT_THR = TW'(ACK_LATENCY - 1);
  localparam logic [TW-1:0] LAT_MAX = TW'(ACK_LATENCY);
  localparam logic [7:0]    COAL    = 8'(ACK_COALESCE);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND_ACK, ST_SEND_NAK} state_t;

  state_t        state_q, state_d;
  logic [11:0]   next_rcv_seq;
  logic [11:0]   diff;
  logic          nak_sched, nak_req, ack_pending, ack_force;
  logic [7:0]    pend_cnt;
  logic [TW-1:0] lat_timer;
  logic          good_in, dup, seq_err, new_nak;
  logic          hs, hs_nak;
  logic          vld_d, an_d;
  logic [11:0]   seq_d;

  // diff in 1..2048 means the TLP is one we already accepted
  assign diff    = next_rcv_seq - bus.rx_seq_num_i;
  assign good_in = bus.rx_tlp_vld_i & bus.rx_lcrc_ok_i & (diff == 12'd0);
  assign dup     = bus.rx_tlp_vld_i & bus.rx_lcrc_ok_i & (diff != 12'd0) & (diff <= 12'd2048);
  assign seq_err = bus.rx_tlp_vld_i & ~(bus.rx_lcrc_ok_i & (diff <= 12'd2048));
  assign new_nak = seq_err & ~nak_sched;

  assign hs     = bus.ack_nack_vld_o & bus.ack_nack_rdy_i;
  assign hs_nak = hs & (state_q == ST_SEND_NAK);
  assign bus.next_rcv_seq_o = next_rcv_seq;

  always_comb begin
    state_d = state_q;
    vld_d   = bus.ack_nack_vld_o;
    an_d    = bus.ack_nack_o;
    seq_d   = bus.ack_seq_num_o;
    case (state_q)
      ST_IDLE: begin
        if (nak_req) begin
          state_d = ST_SEND_NAK;
          vld_d   = 1'b1;
          an_d    = 1'b0;
          seq_d   = next_rcv_seq - 12'd1;
        end else if (ack_force | (ack_pending & ((lat_timer >= LAT_THR) | (pend_cnt >= COAL)))) begin
          state_d = ST_SEND_ACK;
          vld_d   = 1'b1;
          an_d    = 1'b1;
          seq_d   = next_rcv_seq - 12'd1;
        end
      end
      default: begin
        if (hs) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= ST_IDLE;
      next_rcv_seq       <= '0;
      nak_sched          <= 1'b0;
      nak_req            <= 1'b0;
      ack_pending        <= 1'b0;
      ack_force          <= 1'b0;
      pend_cnt           <= '0;
      lat_timer          <= '0;
      bus.tlp_accept_o   <= 1'b0;
      bus.tlp_drop_o     <= 1'b0;
      bus.ack_nack_vld_o <= 1'b0;
      bus.ack_nack_o     <= 1'b0;
      bus.ack_seq_num_o  <= '0;
    end else if (!link_up_i) begin
      // link down abandons any in-flight request without a handshake
      state_q            <= ST_IDLE;
      next_rcv_seq       <= '0;
      nak_sched          <= 1'b0;
      nak_req            <= 1'b0;
      ack_pending        <= 1'b0;
      ack_force          <= 1'b0;
      pend_cnt           <= '0;
      lat_timer          <= '0;
      bus.tlp_accept_o   <= 1'b0;
      bus.tlp_drop_o     <= 1'b0;
      bus.ack_nack_vld_o <= 1'b0;
      bus.ack_nack_o     <= 1'b0;
      bus.ack_seq_num_o  <= '0;
    end else begin
      state_q            <= state_d;
      bus.ack_nack_vld_o <= vld_d;
      bus.ack_nack_o     <= an_d;
      bus.ack_seq_num_o  <= seq_d;
      bus.tlp_accept_o   <= good_in;
      bus.tlp_drop_o     <= bus.rx_tlp_vld_i & ~good_in;
      if (good_in) next_rcv_seq <= next_rcv_seq + 12'd1;
      if (good_in)      nak_sched <= 1'b0;
      else if (seq_err) nak_sched <= 1'b1;
      nak_req   <= (nak_req & ~hs_nak) | new_nak;
      ack_force <= (ack_force & ~hs) | dup;
      // a sent DLLP covers everything accepted so far; a same-cycle accept starts a fresh window
      if (hs) begin
        ack_pending <= good_in;
        pend_cnt    <= good_in ? 8'd1 : 8'd0;
        lat_timer   <= '0;
      end else begin
        if (good_in) begin
          ack_pending <= 1'b1;
          if (pend_cnt != 8'hFF) pend_cnt <= pend_cnt + 8'd1;
        end
        if (!ack_pending)            lat_timer <= '0;
        else if (lat_timer != LAT_MAX) lat_timer <= lat_timer + 1'b1;
      end
    end
  end
endmodule

// File: doc/dll_rx_ack_nak.md
# dll_rx_ack_nak

Receive-side data-link sequence checker for the PCIe DLL. It judges each received TLP by its sequence number and LCRC status, then forwards or drops it. It tracks NEXT_RCV_SEQ and schedules coalesced ACK and single-shot NAK DLLP requests. Those requests feed the DLLP transmit path, which delivers them to the far-end replay buffer's ack/nack inputs.

## Interface
Parameters:
- ACK_LATENCY, default 160: cycles an ACK may be held pending before it is forced out.
- ACK_COALESCE, default 4: number of accepted TLPs that forces an ACK immediately.

Ports (all outputs are registered):
- clk_i, input, 1: single clock.
- rst_ni, input, 1: reset; asynchronous, active-low.
- link_up_i, input, 1: DL_Active. Low performs a synchronous clear to reset values.
- rx_tlp_vld_i, input, 1: one-cycle pulse at the end of each received TLP.
- rx_seq_num_i, input, 12: sequence number of that TLP.
- rx_lcrc_ok_i, input, 1: 1 if the LCRC check passed.
- tlp_accept_o, output, 1: one-cycle pulse; forward the TLP to the transaction layer.
- tlp_drop_o, output, 1: one-cycle pulse; discard the TLP.
- ack_nack_o, output, 1: 1 = ACK, 0 = NAK.
- ack_seq_num_o, output, 12: AckNak_Seq_Num carried in the DLLP.
- ack_nack_vld_o, output, 1: DLLP request valid.
- ack_nack_rdy_i, input, 1: DLLP transmitter accepts the request.
- next_rcv_seq_o, output, 12: current NEXT_RCV_SEQ, for status.

## Operation
State:
- next_rcv_seq: 12-bit.
- nak_sched, ack_pending, ack_force: flags.
- pend_cnt: 8-bit, saturating.
- lat_timer: width $clog2(ACK_LATENCY+1).
- FSM: ST_IDLE, ST_SEND_ACK, ST_SEND_NAK.

TLP classification on rx_tlp_vld_i. All arithmetic is mod 4096, with diff = (next_rcv_seq − rx_seq_num_i) mod 4096.
- LCRC bad: drop. If !nak_sched, set nak_sched and raise a NAK request.
- LCRC good, diff == 0 (in order): accept.
  - Increment next_rcv_seq, wrapping 4095→0.
  - Clear nak_sched.
  - Set ack_pending, increment pend_cnt.
  - If ack_pending was previously 0, lat_timer restarts at 0.
- LCRC good, 1 ≤ diff ≤ 2048 (duplicate): drop; set ack_force.
- LCRC good, otherwise (sequence ahead, lost TLP): drop. If !nak_sched, set nak_sched and raise a NAK request.

Timer:
- lat_timer increments every cycle while ack_pending = 1.
- It holds at 0 while ack_pending = 0.

FSM:
- ST_IDLE, evaluated in priority order:
  1. NAK request → ST_SEND_NAK.
  2. Else if ack_force, or ack_pending with (lat_timer ≥ ACK_LATENCY−1 or pend_cnt ≥ ACK_COALESCE) → ST_SEND_ACK.
  - On entry, capture ack_seq_num_o = next_rcv_seq − 1 and assert ack_nack_vld_o.
  - ack_nack_o = 1 for ACK, 0 for NAK.
- ST_SEND_ACK / ST_SEND_NAK:
  - Hold all output fields stable until ack_nack_vld_o && ack_nack_rdy_i.
  - On that handshake, return to ST_IDLE.
  - Clear ack_pending, pend_cnt, lat_timer, ack_force, and the NAK request if it was the one served.
  - If a TLP is accepted in the handshake cycle, ack_pending = 1, pend_cnt = 1 and lat_timer = 0 after the handshake.
  - nak_sched is NOT cleared by sending; only an in-order good TLP clears it.
- A NAK request raised while in ST_SEND_ACK is kept. It is served from ST_IDLE after the handshake.

Reset values (rst_ni low, or link_up_i low on a clock edge):
- next_rcv_seq = 0; all flags and counters = 0; FSM = ST_IDLE.
- Outputs: tlp_accept_o = 0, tlp_drop_o = 0, ack_nack_vld_o = 0, ack_nack_o = 0, ack_seq_num_o = 0, next_rcv_seq_o = 0.
- An in-flight request is abandoned without a handshake.

## Timing
- The rx_tlp_vld_i pulse is sampled at edge N. At N+1:
  - tlp_accept_o or tlp_drop_o is high for one cycle;
  - next_rcv_seq_o is updated;
  - flags are updated.
- A NAK decided at edge N gives ack_nack_vld_o high at N+2 when the FSM is idle.
- With ACK_COALESCE reached at edge N, ack_nack_vld_o rises at N+2.
- With no coalesce trigger, a lone accepted TLP at edge N gives ACK valid at N+1+ACK_LATENCY.
- Back-to-back rx_tlp_vld_i on every cycle is supported with no stalls; there is no backpressure on the receive side.
- ack_nack_vld_o may stay high indefinitely while ack_nack_rdy_i = 0.
- After a handshake, the next request's valid can appear at the earliest one cycle later, because ST_IDLE takes one cycle.

## Test plan
- In-order TLPs with seq 0,1,2,3, LCRC ok, rdy = 1 → four accept pulses; one ACK with seq 3; next_rcv_seq_o = 4.
- next_rcv_seq = 4095, TLP seq 4095 ok → accept, next_rcv_seq_o = 0; the ACK after ACK_LATENCY carries 4095.
- Bad LCRC on seq 5 (next = 5), then seq 6 ok, then seq 5 ok, with rdy = 1:
  - the bad seq 5 is dropped → exactly one NAK, seq 4;
  - seq 6 is dropped with no second NAK (nak_sched set);
  - the resent seq 5 is accepted, nak_sched clears, and the next ACK carries seq 5.
- Duplicate seq 2 with next = 10 → drop; ACK with seq 9 within 2 cycles, with no timer wait.
- rdy held 0 for 20 cycles while in ST_SEND_ACK and a bad TLP arrives:
  - ACK fields stay stable;
  - after the handshake, a NAK is issued with seq next − 1.
- link_up_i pulled low mid-request (vld = 1) → next cycle vld = 0, next_rcv_seq_o = 0, no handshake is needed, and all counters are cleared.
